// File: rtl/operation_encoder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | operation_encoder: synchronises and debounces five buttons and turns   |
// | them into a per-frame command vector latched on each vsync rising edge.|
// | Optional auto-repeat for RIGHT/LEFT/DOWN: define OPERATION_AUTOREPEAT_EN|
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module operation_encoder #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 12,
  parameter int REPEAT_RATE     = 3
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [4:0] btn,
  input  logic       vsync,
  output logic [4:0] operation,
  output logic       frame_tick
);

  localparam logic [15:0] c_db_max = 16'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535 ||
      REPEAT_DELAY < 1 || REPEAT_DELAY > 255 ||
      REPEAT_RATE < 1 || REPEAT_RATE > 255) begin : g_bad_cfg
    $error("operation_encoder: parameter out of range");
  end

  logic [4:0] btn_meta_q, btn_sync_q;
  logic       vs_meta_q, vs_sync_q, vs_prev_q, frame_tick_q;
  logic [4:0] level, press;
  logic [4:0] w_rep, w_events, w_load, operation_d;
  logic [4:0] pending_q, operation_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      btn_meta_q   <= '0;
      btn_sync_q   <= '0;
      vs_meta_q    <= 1'b0;
      vs_sync_q    <= 1'b0;
      vs_prev_q    <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      btn_meta_q   <= btn;
      btn_sync_q   <= btn_meta_q;
      vs_meta_q    <= vsync;
      vs_sync_q    <= vs_meta_q;
      vs_prev_q    <= vs_sync_q;
      frame_tick_q <= vs_sync_q & ~vs_prev_q;
    end
  end

  for (genvar i = 0; i < 5; i++) begin : g_btn
    logic [15:0] cnt_q;
    logic        level_q;
    logic        press_q;

    // press_q fires in the same clock the debounced level first reads high
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q   <= '0;
        level_q <= 1'b0;
        press_q <= 1'b0;
      end else begin
        press_q <= 1'b0;
        if (btn_sync_q[i] == level_q) begin
          cnt_q <= '0;
        end else if (cnt_q == c_db_max) begin
          cnt_q   <= '0;
          level_q <= btn_sync_q[i];
          press_q <= btn_sync_q[i];
        end else begin
          cnt_q <= cnt_q + 16'd1;
        end
      end
    end

    assign level[i] = level_q;
    assign press[i] = press_q;
  end

`ifdef OPERATION_AUTOREPEAT_EN
  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

  localparam logic [7:0] c_rpt_delay = 8'(REPEAT_DELAY);
  localparam logic [7:0] c_rpt_rate  = 8'(REPEAT_RATE);

  for (genvar i = 0; i < 3; i++) begin : g_rpt
    rpt_state_e state_q;
    logic [7:0] frm_cnt_q;
    logic       rep_q;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        state_q   <= RPT_IDLE;
        frm_cnt_q <= '0;
        rep_q     <= 1'b0;
      end else begin
        rep_q <= 1'b0;
        if (!level[i]) begin
          state_q   <= RPT_IDLE;
          frm_cnt_q <= '0;
        end else if (press[i]) begin
          state_q   <= RPT_DELAY;
          frm_cnt_q <= '0;
        end else begin
          case (state_q)
            RPT_DELAY: begin
              if (frm_cnt_q == c_rpt_delay) begin
                rep_q     <= 1'b1;
                state_q   <= RPT_REPEAT;
                frm_cnt_q <= '0;
              end else if (frame_tick_q) begin
                frm_cnt_q <= frm_cnt_q + 8'd1;
              end
            end
            RPT_REPEAT: begin
              if (frm_cnt_q == c_rpt_rate) begin
                rep_q     <= 1'b1;
                frm_cnt_q <= '0;
              end else if (frame_tick_q) begin
                frm_cnt_q <= frm_cnt_q + 8'd1;
              end
            end
            default: begin
              state_q   <= RPT_IDLE;
              frm_cnt_q <= '0;
            end
          endcase
        end
      end
    end

    assign w_rep[i] = rep_q;
  end
  assign w_rep[4:3] = 2'b00;
`else
  assign w_rep = '0;
`endif

  assign w_events = press | w_rep;
  assign w_load   = pending_q | w_events;

  // Opposing directions in one frame cancel each other out
  always_comb begin
    operation_d = w_load;
    if (w_load[0] && w_load[1]) begin
      operation_d[1:0] = 2'b00;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending_q   <= '0;
      operation_q <= '0;
    end else if (frame_tick_q) begin
      pending_q   <= '0;
      operation_q <= operation_d;
    end else begin
      pending_q   <= w_load;
    end
  end

  assign operation  = operation_q;
  assign frame_tick = frame_tick_q;

endmodule
`default_nettype wire

// File: doc/operation_encoder.md
OPERATION_ENCODER -- requirements
Module: operation_encoder

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000; clocks a raw button must hold a new level before the debounced level changes (range 1..65535).
REQ-002 Parameter REPEAT_DELAY, default 12; frames a LEFT/RIGHT/DOWN button is held before auto-repeat starts (range 1..255).
REQ-003 Parameter REPEAT_RATE, default 3; frames between auto-repeat events after the delay (range 1..255).
REQ-004 clock  input  1  single system clock; all state on rising edge.
REQ-005 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 btn  input  5  raw active-high buttons, asynchronous to clock; bit 0 RIGHT, 1 LEFT, 2 DOWN, 3 ROTATE, 4 START.
REQ-007 vsync  input  1  frame strobe, asynchronous to clock; the consumer samples operation on its falling edge.
REQ-008 operation  output  5  registered per-frame command vector, same bit map as btn.
REQ-009 frame_tick  output  1  one-clock pulse on each detected vsync rising edge.

Function
REQ-010 Each btn bit and vsync SHALL pass through a 2-flop synchronizer before any other use.
REQ-011 Each button SHALL have a 16-bit debounce counter: cleared while synced input equals the debounced level; incremented otherwise; at DEBOUNCE_CYCLES-1 the debounced level flips and the counter clears.
REQ-012 A press event SHALL be a one-clock pulse on a 0->1 debounced transition; releases generate no event.
REQ-013 Press events SHALL OR into a 5-bit pending register; repeated events for the same bit within a frame collapse to one.
REQ-014 frame_tick SHALL assert for exactly one clock when synced vsync goes 0->1 (3-clock latency from the vsync pin).
REQ-015 On frame_tick, operation SHALL load (pending | same-cycle events), and pending SHALL clear in that same clock.
REQ-016 operation SHALL hold its value between frame_ticks, so it is stable across the vsync falling edge.
REQ-017 If the loaded value has both RIGHT and LEFT set, both SHALL be cleared in operation; other bits are unaffected.
REQ-018 An event arriving in the clock after frame_tick SHALL appear in the next frame's operation, never be lost.
REQ-019 ROTATE and START SHALL be edge-only: holding them produces exactly one operation bit per press.
REQ-020 Per button, the auto-repeat FSM SHALL have states IDLE, DELAY, REPEAT with an 8-bit frame counter incremented on frame_tick.
REQ-021 On a debounced press: IDLE->DELAY with counter 0; on a debounced release: any state->IDLE.
REQ-022 In DELAY, when the counter reaches REPEAT_DELAY, the FSM SHALL raise a repeat event, enter REPEAT and clear the counter.
REQ-023 In REPEAT, when the counter reaches REPEAT_RATE, the FSM SHALL raise a repeat event and clear the counter.
REQ-024 Repeat events SHALL be equivalent to press events for REQ-013/REQ-015.
REQ-025 If vsync stops, pending SHALL keep accumulating and operation SHALL hold indefinitely.

Reset
REQ-026 While reset_n is low, SHALL clear synchronizers, debounce counters, debounced levels, pending, operation (5'b00000), frame_tick (0), repeat FSMs (IDLE, counter 0).
REQ-027 Reset asserted mid-frame SHALL discard pending events; the first frame_tick after release loads only events seen after release.
REQ-028 A button held through reset release SHALL produce one press event once DEBOUNCE_CYCLES have elapsed.

Configuration
REQ-029 With macro OPERATION_AUTOREPEAT_EN defined, the REQ-020..REQ-024 FSMs SHALL exist for RIGHT, LEFT and DOWN.
REQ-030 Without OPERATION_AUTOREPEAT_EN, no repeat logic SHALL be built; all five buttons behave as edge-only; REPEAT_DELAY/REPEAT_RATE are ignored.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=2, REPEAT_RATE=1)
REQ-031 Tap RIGHT for 10 clocks, then vsync rise -> operation=5'b00001 for one frame, then 5'b00000 after the next vsync rise.
REQ-032 Bounce LEFT high for 2 clocks, 3 times -> no event; operation stays 5'b00000.
REQ-033 Press RIGHT and LEFT in the same frame plus ROTATE -> operation=5'b01000.
REQ-034 Hold DOWN for 6 frames with the macro defined -> DOWN set in frames 1,3,4,5,6 after the press; without the macro, frame 1 only.
REQ-035 Press START, then assert reset_n low before vsync, release it, then vsync rise -> operation=5'b00000.
REQ-036 Debounced ROTATE press in the same clock as frame_tick -> operation=5'b01000 in that frame; pending is 0 afterward.
